// File: rtl/mem_ctrl.sv
// Byte-serial RAM sequencer shared by instruction fetch and the MEM stage, MEM winning ties.
// Latency: read ack N+1 cycles after accept, write ack N cycles (N = 1/2/4), then one DONE cycle.
// Backpressure: requests are levels held until ack; the other port waits until the controller is IDLE.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_ack_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_ack_o,
    output logic [31:0]       mem_rdata_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_if_q, owner_if_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [2:0] k;
    logic [2:0] beat;
    logic [1:0] samp_idx;

    function automatic logic [2:0] len2n(input logic [1:0] len);
        case (len)
            2'b00:   len2n = 3'd1;
            2'b01:   len2n = 3'd2;
            default: len2n = 3'd4;
        endcase
    endfunction

    // cnt_q counts edges since acceptance; the byte addressed at beat i returns two edges later.
    assign k        = cnt_q + 3'd1;
    assign beat     = (k < n_q) ? k : (n_q - 3'd1);
    assign samp_idx = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        addr_d      = addr_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_a_d     = '0;
        ram_dout_d  = 8'h00;
        ram_wr_d    = 1'b0;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    state_d    = mem_we_i ? WR : RD;
                    owner_if_d = 1'b0;
                    addr_d     = mem_addr_i;
                    n_d        = len2n(mem_len_i);
                    wdata_d    = mem_wdata_i;
                    cnt_d      = 3'd0;
                    buf_d      = 32'h0;
                    ram_a_d    = mem_addr_i;
                    if (mem_we_i) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata_i[7:0];
                    end
                end else if (if_req_i && !if_flush_i) begin
                    state_d    = RD;
                    owner_if_d = 1'b1;
                    addr_d     = if_addr_i;
                    n_d        = 3'd4;
                    cnt_d      = 3'd0;
                    buf_d      = 32'h0;
                    ram_a_d    = if_addr_i;
                end
            end
            RD: begin
                if (owner_if_q && if_flush_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = k;
                    if (cnt_q != 3'd0) begin
                        buf_d[{samp_idx, 3'b000} +: 8] = ram_din_i;
                    end
                    if (cnt_q == n_q) begin
                        state_d = DONE;
                        if (owner_if_q) begin
                            if_ack_d  = 1'b1;
                            if_data_d = buf_d;
                        end else begin
                            mem_ack_d   = 1'b1;
                            mem_rdata_d = buf_d;
                        end
                    end else begin
                        ram_a_d = addr_q + ADDR_W'(beat);
                    end
                end
            end
            WR: begin
                if (k == n_q) begin
                    state_d   = DONE;
                    mem_ack_d = 1'b1;
                end else begin
                    cnt_d      = k;
                    ram_wr_d   = 1'b1;
                    ram_a_d    = addr_q + ADDR_W'(k);
                    ram_dout_d = wdata_q[{k[1:0], 3'b000} +: 8];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_if_q  <= 1'b0;
            addr_q      <= '0;
            n_q         <= 3'd0;
            cnt_q       <= 3'd0;
            wdata_q     <= 32'h0;
            buf_q       <= 32'h0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'h00;
            ram_wr_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_ack_o    = if_ack_q;
    assign if_data_o   = if_data_q;
    assign mem_ack_o   = mem_ack_q;
    assign mem_rdata_o = mem_rdata_q;
    assign ram_a_o     = ram_a_q;
    assign ram_dout_o  = ram_dout_q;
    assign ram_wr_o    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a byte RAM responder plus a shadow memory that predicts load data and timing.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic        if_flush_i = 1'b0;
    logic        if_ack_o;
    logic [31:0] if_data_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_len_i = 2'b00;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic        mem_ack_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  ram_din_i = 8'h00;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_ack_o(if_ack_o), .if_data_o(if_data_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
        .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] tr_a    [0:19];
    logic        tr_wr   [0:19];
    logic [7:0]  tr_dout [0:19];
    logic [31:0] exp_if_data  = 32'h0;
    logic [31:0] exp_mem_data = 32'h0;

    function automatic logic [7:0] rd_ram(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // RAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_a_o] = ram_dout_o;
        ram_din_i <= rd_ram(ram_a_o);
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n);
        logic [31:0] r = 32'h0;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            r[8*i +: 8] = rd_ref(a);
        end
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input int n, input logic [31:0] wdata);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            ref_mem[a] = wdata[8*i +: 8];
        end
    endtask

    // Issues one request from an idle controller, records the RAM side each cycle, returns at the ack.
    task automatic xact(input bit is_if, input bit we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] data,
                        output bit other_ack);
        lat = -1;
        data = 32'h0;
        other_ack = 1'b0;
        if (is_if) begin
            if_req_i = 1'b1;
            if_addr_i = addr;
        end else begin
            mem_req_i = 1'b1;
            mem_we_i = we;
            mem_len_i = len;
            mem_addr_i = addr;
            mem_wdata_i = wdata;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            tr_a[k-1] = ram_a_o;
            tr_wr[k-1] = ram_wr_o;
            tr_dout[k-1] = ram_dout_o;
            if (is_if ? mem_ack_o : if_ack_o) other_ack = 1'b1;
            if (is_if ? if_ack_o : mem_ack_o) begin
                lat = k - 1;
                data = is_if ? if_data_o : mem_rdata_o;
                break;
            end
        end
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
    endtask

    task automatic test_reset;
        int lat;
        logic [31:0] d;
        bit oa;
        bit ok;
        @(negedge clk);
        n_checks++;
        if ({if_ack_o, if_data_o, mem_ack_o, mem_rdata_o, ram_dout_o, ram_a_o, ram_wr_o} !== '0)
            $display("FAIL reset_state: a=%h wr=%b dout=%h acks=%b%b", ram_a_o, ram_wr_o, ram_dout_o, if_ack_o, mem_ack_o);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
        mem_addr_i = 32'h0000_9000; mem_wdata_i = 32'hA5C3_E7F1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({if_ack_o, if_data_o, mem_ack_o, mem_rdata_o, ram_dout_o, ram_a_o, ram_wr_o} !== '0)
            $display("FAIL reset_midburst: a=%h wr=%b dout=%h want all 0", ram_a_o, ram_wr_o, ram_dout_o);
        else n_pass++;
        mem_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ram_wr_o !== 1'b0 || ram_a_o !== 32'h0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) $display("FAIL idle_after_reset: wr=%b a=%h want 0", ram_wr_o, ram_a_o);
        else n_pass++;
        exp_if_data = 32'h0;
        exp_mem_data = 32'h0;
    endtask

    task automatic test_fetch;
        int lat;
        logic [31:0] d;
        bit oa;
        bit ok;
        poke(32'h1000, 8'h13); poke(32'h1001, 8'h00); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
        xact(1'b1, 1'b0, 2'b10, 32'h1000, 32'h0, lat, d, oa);
        n_checks++;
        if (lat !== 5) $display("FAIL fetch_latency: got %0d want 5", lat); else n_pass++;
        n_checks++;
        if (d !== 32'h0000_0013) $display("FAIL fetch_data: got %h want 00000013", d); else n_pass++;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (tr_a[i] !== 32'h1000 + 32'(i) || tr_wr[i] !== 1'b0) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL fetch_addr_seq: got %h %h %h %h", tr_a[0], tr_a[1], tr_a[2], tr_a[3]);
        else n_pass++;
        exp_if_data = 32'h0000_0013;
        @(negedge clk);
        n_checks++;
        if (if_ack_o !== 1'b0) $display("FAIL fetch_ack_pulse: ack still %b", if_ack_o); else n_pass++;
    endtask

    task automatic test_conflict;
        int k_mem = -1;
        int k_if = -1;
        logic [31:0] d_mem = 32'h0;
        logic [31:0] d_if = 32'h0;
        for (int i = 0; i < 4; i++) poke(32'h2000 + 32'(i), 8'($urandom_range(1, 255)));
        if_req_i = 1'b1; if_addr_i = 32'h1000;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = 32'h2000;
        for (int k = 1; k <= 30 && k_if < 0; k++) begin
            @(negedge clk);
            if (mem_ack_o) begin k_mem = k; d_mem = mem_rdata_o; mem_req_i = 1'b0; end
            if (if_ack_o)  begin k_if = k;  d_if = if_data_o;    if_req_i = 1'b0; end
        end
        if_req_i = 1'b0; mem_req_i = 1'b0;
        n_checks++;
        if (k_mem !== 6) $display("FAIL conflict_mem_first: mem ack at cycle %0d want 6", k_mem); else n_pass++;
        // DONE cycle, IDLE cycle, then a 5-edge fetch
        n_checks++;
        if (k_if - k_mem !== 7) $display("FAIL conflict_if_after: if ack %0d cycles after mem, want 7", k_if - k_mem);
        else n_pass++;
        n_checks++;
        if (d_mem !== ref_load(32'h2000, 4) || d_if !== ref_load(32'h1000, 4))
            $display("FAIL conflict_data: mem %h if %h want %h %h", d_mem, d_if, ref_load(32'h2000, 4), ref_load(32'h1000, 4));
        else n_pass++;
        exp_mem_data = ref_load(32'h2000, 4);
        exp_if_data = ref_load(32'h1000, 4);
        @(negedge clk);
    endtask

    task automatic test_byte_store;
        int lat;
        logic [31:0] d;
        bit oa;
        xact(1'b0, 1'b1, 2'b00, 32'h2003, 32'h1234_56AB, lat, d, oa);
        ref_store(32'h2003, 1, 32'h1234_56AB);
        n_checks++;
        if (lat !== 1) $display("FAIL bstore_latency: got %0d want 1", lat); else n_pass++;
        n_checks++;
        if (tr_wr[0] !== 1'b1 || tr_a[0] !== 32'h2003 || tr_dout[0] !== 8'hAB || tr_wr[1] !== 1'b0)
            $display("FAIL bstore_beat: wr=%b a=%h dout=%h next_wr=%b want 1 2003 ab 0", tr_wr[0], tr_a[0], tr_dout[0], tr_wr[1]);
        else n_pass++;
        @(negedge clk);
        poke(32'h2002, 8'h00);
        xact(1'b0, 1'b0, 2'b01, 32'h2002, 32'h0, lat, d, oa);
        n_checks++;
        if (lat !== 3 || d !== 32'h0000_AB00) $display("FAIL half_load: lat %0d data %h want 3 0000ab00", lat, d);
        else n_pass++;
        exp_mem_data = 32'h0000_AB00;
        @(negedge clk);
    endtask

    task automatic test_flush;
        int m_ack = -1;
        bit saw_if_ack = 1'b0;
        logic [31:0] wd;
        wd = $urandom;
        if_req_i = 1'b1; if_addr_i = 32'h1000;
        @(negedge clk);
        @(negedge clk);
        if_flush_i = 1'b1; if_req_i = 1'b0;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h3100; mem_wdata_i = wd;
        @(negedge clk);
        if_flush_i = 1'b0;
        n_checks++;
        if (if_ack_o !== 1'b0 || ram_a_o !== 32'h0 || ram_wr_o !== 1'b0)
            $display("FAIL flush_idle: ack=%b a=%h wr=%b want 0 0 0", if_ack_o, ram_a_o, ram_wr_o);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ram_wr_o !== 1'b1 || ram_a_o !== 32'h3100 || ram_dout_o !== wd[7:0])
            $display("FAIL flush_store_accept: wr=%b a=%h dout=%h want 1 3100 %h", ram_wr_o, ram_a_o, ram_dout_o, wd[7:0]);
        else n_pass++;
        for (int m = 1; m <= 10; m++) begin
            if (if_ack_o) saw_if_ack = 1'b1;
            if (mem_ack_o) begin m_ack = m; break; end
            @(negedge clk);
        end
        mem_req_i = 1'b0;
        ref_store(32'h3100, 4, wd);
        n_checks++;
        if (m_ack !== 5 || saw_if_ack || if_data_o !== exp_if_data)
            $display("FAIL flush_store_done: ack cyc %0d if_ack %b if_data %h want 5 0 %h", m_ack, saw_if_ack, if_data_o, exp_if_data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        int lat;
        logic [31:0] d;
        bit oa;
        poke(32'hFFFF_FFFE, 8'h11); poke(32'hFFFF_FFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);
        xact(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, lat, d, oa);
        n_checks++;
        if (tr_a[0] !== 32'hFFFF_FFFE || tr_a[1] !== 32'hFFFF_FFFF || tr_a[2] !== 32'h0 || tr_a[3] !== 32'h1)
            $display("FAIL wrap_addr: got %h %h %h %h", tr_a[0], tr_a[1], tr_a[2], tr_a[3]);
        else n_pass++;
        n_checks++;
        if (lat !== 5 || d !== 32'h4433_2211) $display("FAIL wrap_data: lat %0d data %h want 5 44332211", lat, d);
        else n_pass++;
        exp_mem_data = 32'h4433_2211;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [31:0] d;
        bit oa;
        bit ok;
        bit is_if;
        bit we;
        logic [1:0] len;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        int n;
        for (int t = 0; t < 40; t++) begin
            is_if = ($urandom_range(0, 2) == 0);
            we = !is_if && $urandom_range(0, 1) == 1;
            len = 2'($urandom_range(0, 3));
            addr = (t % 8 == 7) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'h3000 + 32'($urandom_range(0, 23));
            wd = $urandom;
            n = is_if ? 4 : nbytes(len);
            exp_d = ref_load(addr, n);
            xact(is_if, we, len, addr, wd, lat, d, oa);
            n_checks++;
            if (lat !== (we ? n : n + 1)) $display("FAIL rnd_latency[%0d]: got %0d want %0d", t, lat, we ? n : n + 1);
            else n_pass++;
            ok = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (tr_a[i] !== addr + 32'(i) || tr_wr[i] !== we) ok = 1'b0;
                if (we && tr_dout[i] !== wd[8*i +: 8]) ok = 1'b0;
            end
            n_checks++;
            if (!ok || oa) $display("FAIL rnd_beats[%0d]: a0=%h wr0=%b other_ack=%b addr=%h", t, tr_a[0], tr_wr[0], oa, addr);
            else n_pass++;
            if (we) begin
                ref_store(addr, n, wd);
                n_checks++;
                if (mem_rdata_o !== exp_mem_data || if_data_o !== exp_if_data)
                    $display("FAIL rnd_hold[%0d]: rdata %h if_data %h want %h %h", t, mem_rdata_o, if_data_o, exp_mem_data, exp_if_data);
                else n_pass++;
            end else begin
                n_checks++;
                if (d !== exp_d) $display("FAIL rnd_data[%0d]: got %h want %h", t, d, exp_d);
                else n_pass++;
                if (is_if) exp_if_data = exp_d; else exp_mem_data = exp_d;
                n_checks++;
                if ((is_if ? mem_rdata_o : if_data_o) !== (is_if ? exp_mem_data : exp_if_data))
                    $display("FAIL rnd_hold[%0d]: other port data %h", t, is_if ? mem_rdata_o : if_data_o);
                else n_pass++;
            end
            @(negedge clk);
            n_checks++;
            if (if_ack_o !== 1'b0 || mem_ack_o !== 1'b0) $display("FAIL rnd_pulse[%0d]: acks %b%b want 00", t, if_ack_o, mem_ack_o);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_conflict;
        test_byte_store;
        test_flush;
        test_wrap;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
